// File: rtl/piso_pkg.sv
// Shared types and elaboration limits for the MSB-first parallel-to-serial stage.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 32;
    localparam int MAX_GAP   = 15;

endpackage

// File: rtl/piso_msb_serializer_if.sv
// Word-in / bit-out bus of the serializer; master is the upstream word source.
interface piso_msb_serializer_if #(
    parameter int WIDTH = 8
);

    // A word moves on a rising edge where in_valid && in_ready; in_data is only
    // looked at on that edge, and in_valid may drop at any time without effect.
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             data_out;
    logic             bit_valid;
    logic             sof;
    logic             eof;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, data_out, bit_valid, sof, eof, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, data_out, bit_valid, sof, eof, busy
    );

endinterface

// File: rtl/piso_msb_serializer.sv
// Parallel-in, serial-out stage: emits accepted words MSB first, one bit per clock,
// with sof/eof frame markers and an optional forced idle gap between words.
module piso_msb_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int IDLE_GAP = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    piso_msb_serializer_if.slave        bus,
    output state_t                      state
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = $clog2(MAX_GAP + 1);
    localparam logic [CW-1:0] LAST_IDX     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST_IDX = CW'(WIDTH - 2);
    localparam logic [GW-1:0] GAP_LOAD     = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic          NO_GAP       = (IDLE_GAP == 0);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("piso_msb_serializer: WIDTH out of range 2..32");
    end
    if (IDLE_GAP < 0 || IDLE_GAP > MAX_GAP) begin : g_bad_gap
        $error("piso_msb_serializer: IDLE_GAP out of range 0..15");
    end

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [GW-1:0]    gap_cnt;
    logic             last_bit;
    logic             ready;
    logic             accept;

    // cnt is the index of the bit currently on data_out; shreg[WIDTH-1] is that bit.
    always_comb begin
        last_bit = (state == SHIFT) && (cnt == LAST_IDX);
        ready    = (state == IDLE) || (last_bit && NO_GAP);
        accept   = bus.in_valid && ready;
    end

    assign bus.in_ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shreg         <= '0;
            cnt           <= '0;
            gap_cnt       <= '0;
            bus.data_out  <= 1'b0;
            bus.bit_valid <= 1'b0;
            bus.sof       <= 1'b0;
            bus.eof       <= 1'b0;
            bus.busy      <= 1'b0;
        end else if (accept) begin
            state         <= SHIFT;
            shreg         <= bus.in_data;
            cnt           <= '0;
            bus.data_out  <= bus.in_data[WIDTH-1];
            bus.bit_valid <= 1'b1;
            bus.sof       <= 1'b1;
            bus.eof       <= 1'b0;
            bus.busy      <= 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    if (!last_bit) begin
                        shreg         <= shreg << 1;
                        cnt           <= cnt + 1'b1;
                        bus.data_out  <= shreg[WIDTH-2];
                        bus.bit_valid <= 1'b1;
                        bus.sof       <= 1'b0;
                        bus.eof       <= (cnt == PRE_LAST_IDX);
                        bus.busy      <= 1'b1;
                    end else begin
                        bus.data_out  <= 1'b0;
                        bus.bit_valid <= 1'b0;
                        bus.sof       <= 1'b0;
                        bus.eof       <= 1'b0;
                        if (NO_GAP) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state    <= GAP;
                            gap_cnt  <= GAP_LOAD;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                // gap_cnt counts down so GAP lasts exactly IDLE_GAP cycles.
                GAP: begin
                    if (gap_cnt == '0) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                IDLE: begin
                    bus.busy <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    bus.data_out  <= 1'b0;
                    bus.bit_valid <= 1'b0;
                    bus.sof       <= 1'b0;
                    bus.eof       <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_msb_serializer.sv
// Bench for piso_msb_serializer: directed scenarios plus a randomized run against
// a word-level model of the serial stream (one DUT with no gap, one with IDLE_GAP=2).
module tb_piso_msb_serializer;
    import piso_pkg::*;

    localparam int W = 8;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_t st0;
    state_t st2;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected stream entries: {sof, eof, bit}
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    piso_msb_serializer_if #(.WIDTH(W)) bus0 ();
    piso_msb_serializer_if #(.WIDTH(W)) bus2 ();

    piso_msb_serializer #(.WIDTH(W), .IDLE_GAP(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0),
        .state (st0)
    );

    piso_msb_serializer #(.WIDTH(W), .IDLE_GAP(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2),
        .state (st2)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [4:0] obs;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        obs = {bus0.data_out, bus0.bit_valid, bus0.sof, bus0.eof, bus0.busy};
        n_checks++;
        if (obs !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs_dut0: got %b expected 00000", obs);
        end
        obs = {bus2.data_out, bus2.bit_valid, bus2.sof, bus2.eof, bus2.busy};
        n_checks++;
        if (obs !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs_dut2: got %b expected 00000", obs);
        end
        n_checks++;
        if (bus0.in_ready !== 1'b1 || bus2.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b%b expected 11", bus0.in_ready, bus2.in_ready);
        end
        n_checks++;
        if (st0 !== IDLE || st2 !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d/%0d expected IDLE", st0, st2);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus0.bit_valid, bus0.busy, bus0.in_ready} !== 3'b001) begin
            n_fail++; $display("FAIL post_reset_idle: got %b expected 001", {bus0.bit_valid, bus0.busy, bus0.in_ready});
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] w = 8'hA5;
        logic [3:0]   obs;
        logic [3:0]   exp;
        @(negedge clk);
        n_checks++;
        if (bus0.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_ready: got %b expected 1", bus0.in_ready);
        end
        bus0.in_data  = w;
        bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        bus0.in_data  = W'($urandom);
        for (int k = 0; k < W; k++) begin
            obs = {bus0.data_out, bus0.bit_valid, bus0.sof, bus0.eof};
            exp = {w[W-1-k], 1'b1, (k == 0), (k == W-1)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL single_bit%0d: got %b expected %b", k, obs, exp);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({bus0.bit_valid, bus0.busy, bus0.data_out} !== 3'b000) begin
            n_fail++; $display("FAIL single_after: got %b expected 000", {bus0.bit_valid, bus0.busy, bus0.data_out});
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        logic [4:0]   obs;
        logic [4:0]   exp;
        int           k;
        @(negedge clk);
        bus0.in_data  = 8'hFF;
        bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_data  = 8'h00;
        for (int c = 1; c <= 2*W; c++) begin
            w   = (c <= W) ? 8'hFF : 8'h00;
            k   = (c - 1) % W;
            obs = {bus0.data_out, bus0.bit_valid, bus0.sof, bus0.eof, bus0.in_ready};
            exp = {w[W-1-k], 1'b1, (k == 0), (k == W-1), (k == W-1)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL b2b_bit%0d: got %b expected %b", c, obs, exp);
            end
            if (c == W + 1) bus0.in_valid = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if ({bus0.bit_valid, bus0.busy} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_after: got %b expected 00", {bus0.bit_valid, bus0.busy});
        end
    endtask

    task automatic test_idle_gap();
        logic [W-1:0] words [2];
        logic [W-1:0] w;
        logic [2:0]   obs;
        logic [2:0]   exp;
        int           k = 0;
        int           wi = 0;
        int           gap_n = 0;
        words[0] = 8'h81;
        words[1] = 8'h7E;
        @(negedge clk);
        bus2.in_data  = words[0];
        bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_data  = words[1];
        for (int c = 0; c < 40 && wi < 2; c++) begin
            if (bus2.bit_valid) begin
                w   = words[wi];
                obs = {bus2.data_out, bus2.sof, bus2.eof};
                exp = {w[W-1-k], (k == 0), (k == W-1)};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++; $display("FAIL gap_word%0d_bit%0d: got %b expected %b", wi, k, obs, exp);
                end
                if (wi == 1) bus2.in_valid = 1'b0;
                if (k == W-1) begin
                    k = 0;
                    wi++;
                end else begin
                    k++;
                end
            end else if (wi == 1 && k == 0 && !bus2.in_ready) begin
                gap_n++;
            end
            @(negedge clk);
        end
        bus2.in_valid = 1'b0;
        n_checks++;
        if (wi != 2) begin
            n_fail++; $display("FAIL gap_timeout: got %0d words expected 2", wi);
        end
        n_checks++;
        if (gap_n != 2) begin
            n_fail++; $display("FAIL gap_cycles: got %0d expected 2", gap_n);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if ({bus2.busy, bus2.in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL gap_return_idle: got %b expected 01", {bus2.busy, bus2.in_ready});
        end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] w = 8'hC3;
        logic [3:0]   obs;
        logic [3:0]   exp;
        @(negedge clk);
        bus0.in_data  = w;
        bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            obs = {bus0.data_out, bus0.bit_valid, bus0.sof, bus0.eof};
            exp = {w[W-1-k], 1'b1, (k == 0), 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rstmid_bit%0d: got %b expected %b", k, obs, exp);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus0.data_out, bus0.bit_valid, bus0.sof, bus0.eof, bus0.busy} !== 5'b0) begin
            n_fail++; $display("FAIL rstmid_async_clear: got %b expected 00000",
                               {bus0.data_out, bus0.bit_valid, bus0.sof, bus0.eof, bus0.busy});
        end
        n_checks++;
        if (bus0.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_ready: got %b expected 1", bus0.in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus0.bit_valid, bus0.in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rstmid_release: got %b expected 01", {bus0.bit_valid, bus0.in_ready});
        end
        w = 8'h01;
        bus0.in_data  = w;
        bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            obs = {bus0.data_out, bus0.bit_valid, bus0.sof, bus0.eof};
            exp = {w[W-1-k], 1'b1, (k == 0), (k == W-1)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rstmid_new_bit%0d: got %b expected %b", k, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div5_stream();
        logic [W-1:0] det_exp = 8'b1111_0011;
        int           r = 0;
        logic         det;
        @(negedge clk);
        bus0.in_data  = 8'd10;
        bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            n_checks++;
            if (bus0.bit_valid !== 1'b1) begin
                n_fail++; $display("FAIL div5_valid%0d: got %b expected 1", k, bus0.bit_valid);
            end
            r   = (2 * r + int'(bus0.data_out)) % 5;
            det = (r == 0);
            n_checks++;
            if (det !== det_exp[W-1-k]) begin
                n_fail++; $display("FAIL div5_det%0d: got %b expected %b", k + 1, det, det_exp[W-1-k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w;
        logic [3:0]   obs;
        logic [3:0]   exp;
        bus0.in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus0.in_data = W'($urandom);
            obs = {bus0.in_ready, bus0.bit_valid, bus0.data_out, bus0.busy};
            n_checks++;
            if (obs !== 4'b1000) begin
                n_fail++; $display("FAIL bp_idle%0d: got %b expected 1000", c, obs);
            end
        end
        @(negedge clk);
        w = W'($urandom);
        bus0.in_data  = w;
        bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            obs = {bus0.data_out, bus0.bit_valid, bus0.sof, bus0.eof};
            exp = {w[W-1-k], 1'b1, (k == 0), (k == W-1)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL bp_word_bit%0d: got %b expected %b", k, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int         pct;
        logic       exp_ready;
        logic [2:0] e;
        logic [4:0] obs;
        logic [4:0] exp;
        exp_q.delete();
        for (int c = 0; c < 420; c++) begin
            pct = (c < 140) ? 30 : (c < 280) ? 70 : (c < 400) ? 100 : 0;
            @(negedge clk);
            exp_ready = (exp_q.size() <= 1);
            n_checks++;
            if (bus0.in_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready_c%0d: got %b expected %b", c, bus0.in_ready, exp_ready);
            end
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                exp = {1'b1, e[0], e[2], e[1], 1'b1};
            end else begin
                exp = 5'b0;
            end
            obs = {bus0.bit_valid, bus0.data_out, bus0.sof, bus0.eof, bus0.busy};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rand_stream_c%0d: got %b expected %b", c, obs, exp);
            end
            bus0.in_valid = ($urandom_range(0, 99) < pct);
            bus0.in_data  = W'($urandom);
            if (bus0.in_valid && exp_ready) begin
                for (int k = 0; k < W; k++)
                    exp_q.push_back({(k == 0), (k == W-1), bus0.in_data[W-1-k]});
            end
        end
        bus0.in_valid = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rand_drain: %0d bits outstanding expected 0", exp_q.size());
        end
    endtask

    initial begin
        bus0.in_data  = '0;
        bus0.in_valid = 1'b0;
        bus2.in_data  = '0;
        bus2.in_valid = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_idle_gap();
        test_reset_mid_word();
        test_div5_stream();
        test_backpressure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
